button_event: RTL and testbench
===============================

BUTTON_EVENT -- requirements
Module: button_event

Interface
REQ-001 Parameter LONG_CYCLES, default 25000000, hold time in clk cycles before a long press is declared; legal range 2 to 2^32-1.
REQ-002 Parameter REPEAT_CYCLES, default 5000000, auto-repeat period in clk cycles while held; legal range 1 to 2^32-1.
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 btn_level  input  1  debounced button level, already synchronous to clk; 1 = pressed.
REQ-006 repeat_en  input  1  1 = generate auto-repeat pulses while in HELD.
REQ-007 press_pulse  output  1  one-cycle pulse on press.
REQ-008 click_pulse  output  1  one-cycle pulse on a release from DOWN (short press).
REQ-009 long_pulse  output  1  one-cycle pulse on entry to HELD.
REQ-010 repeat_pulse  output  1  one-cycle pulse each repeat period in HELD.
REQ-011 release_pulse  output  1  one-cycle pulse on any release.
REQ-012 state  output  2  current FSM state: 00 IDLE, 01 DOWN, 10 HELD.

Function
REQ-013 All outputs SHALL be registered; each pulse SHALL be high for exactly one clk cycle per event.
REQ-014 IDLE, btn_level=1 at edge E: the block SHALL go to DOWN, clear hold_cnt to 0 and assert press_pulse in the cycle following E.
REQ-015 DOWN, btn_level=1, hold_cnt<LONG_CYCLES-1: hold_cnt SHALL increment by 1.
REQ-016 DOWN, btn_level=1, hold_cnt==LONG_CYCLES-1: the block SHALL go to HELD, assert long_pulse and clear rep_cnt to 0; long_pulse is therefore registered at edge E+LONG_CYCLES.
REQ-017 DOWN, btn_level=0: the block SHALL go to IDLE and assert click_pulse and release_pulse in the same cycle.
REQ-018 HELD, btn_level=1, repeat_en=1: rep_cnt SHALL increment; at the edge where rep_cnt==REPEAT_CYCLES-1 the block SHALL assert repeat_pulse and clear rep_cnt to 0.
REQ-019 HELD, repeat_en=0: rep_cnt SHALL hold at 0 and repeat_pulse SHALL stay 0; a re-asserted repeat_en SHALL start a full period from 0.
REQ-020 HELD, btn_level=0: the block SHALL go to IDLE and assert release_pulse only (no click_pulse).
REQ-021 Release on the terminal-count edge of REQ-016 or REQ-018: release SHALL take priority; no long_pulse or repeat_pulse is issued.
REQ-022 IDLE, btn_level=0: no pulses; counters SHALL hold.
REQ-023 hold_cnt and rep_cnt SHALL be 32 bits and never wrap; terminal compares SHALL be exact equality.
REQ-024 Illegal state encoding 11 SHALL return to IDLE on the next edge with no pulse.
REQ-025 A press that starts in the same cycle as a release pulse SHALL be recognised on the next edge at which btn_level=1 in IDLE.

Reset
REQ-026 reset=1 SHALL immediately force state=IDLE, hold_cnt=0, rep_cnt=0 and all pulse outputs to 0, independent of clk.
REQ-027 Reset asserted mid-press SHALL discard the press; after deassertion, if btn_level is already 1, the first rising edge SHALL be treated as a new press per REQ-014.

Verification (LONG_CYCLES=8, REPEAT_CYCLES=4)
REQ-028 Short press: btn_level high for 3 cycles -> press_pulse 1 cycle after the rise; click_pulse and release_pulse together 1 cycle after the fall; no long_pulse.
REQ-029 Long hold, repeat_en=1: btn_level high for 20 cycles -> long_pulse at rise+8; repeat_pulse at rise+12 and rise+16; release_pulse after the fall; no click_pulse.
REQ-030 Boundary: btn_level falls exactly on the terminal-count edge at rise+8 -> click_pulse and release_pulse asserted, long_pulse never asserted.
REQ-031 repeat_en=0 throughout a 20-cycle hold -> long_pulse once; zero repeat_pulse.
REQ-032 Reset pulse at rise+5 during a hold, btn_level kept high -> outputs 0 and state=00 at once; after deassertion, press_pulse fires again and long_pulse follows 8 cycles after that restart.

Source files
------------

// File: rtl/button_event_if.sv
// Signal bundle between a button-event detector and its consumer.
// The slave modport is the detector; the master drives the button level and repeat enable.
interface button_event_if;
  logic       btn_level;
  logic       repeat_en;
  logic       press_pulse;
  logic       click_pulse;
  logic       long_pulse;
  logic       repeat_pulse;
  logic       release_pulse;
  logic [1:0] state;

  modport master (
    output btn_level,
    output repeat_en,
    input  press_pulse,
    input  click_pulse,
    input  long_pulse,
    input  repeat_pulse,
    input  release_pulse,
    input  state
  );

  modport slave (
    input  btn_level,
    input  repeat_en,
    output press_pulse,
    output click_pulse,
    output long_pulse,
    output repeat_pulse,
    output release_pulse,
    output state
  );
endinterface

// File: rtl/button_event.sv
// Turns a debounced button level into press/click/long/repeat/release pulses.
// All outputs are registered; each pulse lasts one clock.
module button_event #(
  parameter int unsigned LONG_CYCLES   = 32'd25000000,
  parameter int unsigned REPEAT_CYCLES = 32'd5000000
) (
  input  logic          clk,
  input  logic          reset,
  button_event_if.slave evt_io
);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StDown = 2'b01,
    StHeld = 2'b10
  } state_e;

  localparam logic [31:0] LongLast = 32'(LONG_CYCLES - 1);
  localparam logic [31:0] RepLast  = 32'(REPEAT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [31:0] hold_cnt_q, hold_cnt_d;
  logic [31:0] rep_cnt_q, rep_cnt_d;
  logic        press_q, press_d;
  logic        click_q, click_d;
  logic        long_q, long_d;
  logic        repeat_q, repeat_d;
  logic        release_q, release_d;

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    rep_cnt_d  = rep_cnt_q;
    press_d    = 1'b0;
    click_d    = 1'b0;
    long_d     = 1'b0;
    repeat_d   = 1'b0;
    release_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (evt_io.btn_level) begin
          state_d    = StDown;
          hold_cnt_d = '0;
          press_d    = 1'b1;
        end
      end

      // Release is tested first so it wins over the terminal-count edge.
      StDown: begin
        if (!evt_io.btn_level) begin
          state_d   = StIdle;
          click_d   = 1'b1;
          release_d = 1'b1;
        end else if (hold_cnt_q == LongLast) begin
          state_d   = StHeld;
          long_d    = 1'b1;
          rep_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 32'd1;
        end
      end

      // With repeat disabled the counter parks at 0 so a re-enable starts a full period.
      StHeld: begin
        if (!evt_io.btn_level) begin
          state_d   = StIdle;
          release_d = 1'b1;
        end else if (!evt_io.repeat_en) begin
          rep_cnt_d = '0;
        end else if (rep_cnt_q == RepLast) begin
          repeat_d  = 1'b1;
          rep_cnt_d = '0;
        end else begin
          rep_cnt_d = rep_cnt_q + 32'd1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      hold_cnt_q <= '0;
      rep_cnt_q  <= '0;
      press_q    <= 1'b0;
      click_q    <= 1'b0;
      long_q     <= 1'b0;
      repeat_q   <= 1'b0;
      release_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      rep_cnt_q  <= rep_cnt_d;
      press_q    <= press_d;
      click_q    <= click_d;
      long_q     <= long_d;
      repeat_q   <= repeat_d;
      release_q  <= release_d;
    end
  end

  assign evt_io.press_pulse   = press_q;
  assign evt_io.click_pulse   = click_q;
  assign evt_io.long_pulse    = long_q;
  assign evt_io.repeat_pulse  = repeat_q;
  assign evt_io.release_pulse = release_q;
  assign evt_io.state         = state_q;

endmodule

// File: tb/tb_button_event.sv
// Directed bench for button_event with LONG_CYCLES=8, REPEAT_CYCLES=4.
// Expected pulses per cycle come from a hand-written table plus a few explicit sequences.
module tb_button_event;

  localparam int unsigned LongCycles = 8;
  localparam int unsigned RepCycles  = 4;

  // Pulse vector order: {press, click, long, repeat, release}
  localparam logic [4:0] PNone   = 5'b00000;
  localparam logic [4:0] PPress  = 5'b10000;
  localparam logic [4:0] PClkRel = 5'b01001;
  localparam logic [4:0] PLong   = 5'b00100;
  localparam logic [4:0] PRep    = 5'b00010;
  localparam logic [4:0] PRel    = 5'b00001;

  localparam logic [1:0] SIdle = 2'b00;
  localparam logic [1:0] SDown = 2'b01;
  localparam logic [1:0] SHeld = 2'b10;

  typedef struct {
    logic       btn;
    logic       ren;
    logic [4:0] pulses;
    logic [1:0] st;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t vecs[$];

  button_event_if evt_if ();

  button_event #(
    .LONG_CYCLES  (LongCycles),
    .REPEAT_CYCLES(RepCycles)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .evt_io(evt_if.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] obs();
    return {evt_if.press_pulse, evt_if.click_pulse, evt_if.long_pulse,
            evt_if.repeat_pulse, evt_if.release_pulse, evt_if.state};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic b, input logic r, input logic [4:0] p, input logic [1:0] s);
    vec_t v;
    v.btn = b;
    v.ren = r;
    v.pulses = p;
    v.st = s;
    vecs.push_back(v);
  endtask

  task automatic add_n(input int n, input logic b, input logic r, input logic [4:0] p,
                       input logic [1:0] s);
    for (int i = 0; i < n; i++) add(b, r, p, s);
  endtask

  initial begin
    int n_long;
    int n_rep;
    int long_at;

    // Short press: 3 cycles high
    add(1, 0, PPress, SDown);
    add_n(2, 1, 0, PNone, SDown);
    add(0, 0, PClkRel, SIdle);
    add(0, 0, PNone, SIdle);
    // Long hold 20 cycles with repeat; release lands on a repeat terminal edge
    add(1, 1, PPress, SDown);
    add_n(7, 1, 1, PNone, SDown);
    add(1, 1, PLong, SHeld);
    add_n(3, 1, 1, PNone, SHeld);
    add(1, 1, PRep, SHeld);
    add_n(3, 1, 1, PNone, SHeld);
    add(1, 1, PRep, SHeld);
    add_n(3, 1, 1, PNone, SHeld);
    add(0, 1, PRel, SIdle);
    add(0, 1, PNone, SIdle);
    // Release on the long terminal edge, then an immediate re-press
    add(1, 0, PPress, SDown);
    add_n(7, 1, 0, PNone, SDown);
    add(0, 0, PClkRel, SIdle);
    add(1, 0, PPress, SDown);
    add(0, 0, PClkRel, SIdle);
    add(0, 0, PNone, SIdle);
    // Repeat disabled mid-period restarts a full period on re-enable
    add(1, 1, PPress, SDown);
    add_n(7, 1, 1, PNone, SDown);
    add(1, 1, PLong, SHeld);
    add_n(2, 1, 1, PNone, SHeld);
    add_n(2, 1, 0, PNone, SHeld);
    add_n(3, 1, 1, PNone, SHeld);
    add(1, 1, PRep, SHeld);
    add(0, 1, PRel, SIdle);
    // Idle stays quiet
    add_n(3, 0, 1, PNone, SIdle);

    reset = 1'b1;
    evt_if.btn_level = 1'b0;
    evt_if.repeat_en = 1'b0;
    #1;
    check("reset_async", 32'(obs()), 32'h0);
    repeat (3) tick();
    check("reset_held", 32'(obs()), 32'h0);
    #2 reset = 1'b0;
    tick();
    check("idle_after_reset", 32'(obs()), 32'h0);

    foreach (vecs[i]) begin
      evt_if.btn_level = vecs[i].btn;
      evt_if.repeat_en = vecs[i].ren;
      tick();
      check($sformatf("vec%0d", i), 32'(obs()), 32'({vecs[i].pulses, vecs[i].st}));
    end

    // 20-cycle hold with repeat disabled: one long pulse, no repeats
    evt_if.repeat_en = 1'b0;
    evt_if.btn_level = 1'b1;
    n_long = 0;
    n_rep = 0;
    long_at = -1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (evt_if.long_pulse) begin
        n_long++;
        long_at = k;
      end
      if (evt_if.repeat_pulse) n_rep++;
    end
    check("norep_long_count", 32'(n_long), 32'd1);
    check("norep_long_at", 32'(long_at), 32'd8);
    check("norep_rep_count", 32'(n_rep), 32'd0);
    evt_if.btn_level = 1'b0;
    tick();
    check("norep_release", 32'(obs()), 32'({PRel, SIdle}));
    tick();

    // Reset during a hold discards the press; held button re-presses after release of reset
    evt_if.repeat_en = 1'b1;
    evt_if.btn_level = 1'b1;
    tick();
    check("rst_seq_press", 32'(obs()), 32'({PPress, SDown}));
    repeat (4) tick();
    check("rst_seq_down", 32'(obs()), 32'({PNone, SDown}));
    #2 reset = 1'b1;
    #1;
    check("rst_mid_async", 32'(obs()), 32'h0);
    tick();
    check("rst_mid_held", 32'(obs()), 32'h0);
    #2 reset = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      tick();
      if (k == 0) check("rst_restart_k0", 32'(obs()), 32'({PPress, SDown}));
      else if (k == 8) check("rst_restart_long", 32'(obs()), 32'({PLong, SHeld}));
      else check($sformatf("rst_restart_k%0d", k), 32'(obs()), 32'({PNone, SDown}));
    end
    evt_if.btn_level = 1'b0;
    tick();
    check("rst_restart_rel", 32'(obs()), 32'({PRel, SIdle}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
